uart_frame_parser: RTL and testbench

Byte-to-frame assembler between the UART byte receiver and `uart_reg_mapper`. It consumes single received bytes (`rx_data` qualified by `rx_done`) and validates a fixed 14-byte command frame: two header bytes, a function code, ten payload bytes and a checksum. Only on a good frame does it update the held `func_reg`/`rev_data1..10` outputs and pulse `pack_done`, so the register mapper never sees partial or corrupt commands.

---
 rtl/uart_frame_parser.sv | 172 +++++++++++++++++
 tb/tb_uart_frame_parser.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser
//   Assembles single UART bytes into a fixed 14-byte command frame:
//     HEAD0 HEAD1 FUNC D1..D10 CHK
//   CHK is the 8-bit sum of FUNC and D1..D10. Only a frame with a good CHK
//   updates the held outputs, so downstream logic never sees partial frames.
//
//   Ports
//     clk_50M              in   system clock
//     rst                  in   synchronous active-high reset
//     rx_data[7:0]         in   received byte, valid while rx_done=1
//     rx_done              in   one-cycle byte strobe
//     func_reg[7:0]        out  function code of last good frame
//     rev_data1..10[7:0]   out  payload bytes of last good frame
//     pack_done            out  one-cycle pulse, outputs were updated
//     chk_err              out  one-cycle pulse, frame dropped on bad checksum
//     timeout_err          out  one-cycle pulse, frame aborted by inter-byte timeout
//
//   state  | meaning
//   IDLE   | hunting for HEAD0
//   HDR1   | HEAD0 seen, expecting HEAD1
//   FUNC   | expecting function code
//   DATA   | collecting the ten payload bytes
//   CHK    | expecting checksum byte
module uart_frame_parser #(
    parameter logic [7:0]  _HEAD0          = 8'h55,
    parameter logic [7:0]  _HEAD1          = 8'hAA,
    parameter int unsigned _TIMEOUT_CYCLES = 50000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_done,
    output logic [7:0] func_reg,
    output logic [7:0] rev_data1,
    output logic [7:0] rev_data2,
    output logic [7:0] rev_data3,
    output logic [7:0] rev_data4,
    output logic [7:0] rev_data5,
    output logic [7:0] rev_data6,
    output logic [7:0] rev_data7,
    output logic [7:0] rev_data8,
    output logic [7:0] rev_data9,
    output logic [7:0] rev_data10,
    output logic       pack_done,
    output logic       chk_err,
    output logic       timeout_err
);

    localparam int              CW = $clog2(_TIMEOUT_CYCLES);
    localparam logic [CW-1:0]   TC = CW'(_TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_FUNC,
        S_DATA,
        S_CHK
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_idle_cnt;
    logic [7:0]      r_sum;
    logic [3:0]      r_idx;
    logic [7:0]      r_func_sh;
    logic [7:0]      r_shadow [10];
    logic [7:0]      r_func_out;
    logic [7:0]      r_out    [10];
    // Checksum verdict is registered first and applied one edge later,
    // which gives the one-cycle output latency after the checksum byte.
    logic            r_good;
    logic            r_bad;
    logic            r_pack_done;
    logic            r_chk_err;
    logic            r_timeout_err;
    logic            w_timeout;

    // A byte arriving on the terminal count wins over the timeout.
    assign w_timeout = (r_state != S_IDLE) && !rx_done && (r_idle_cnt == TC);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_idle_cnt    <= '0;
            r_sum         <= '0;
            r_idx         <= '0;
            r_func_sh     <= '0;
            r_shadow      <= '{default: '0};
            r_func_out    <= '0;
            r_out         <= '{default: '0};
            r_good        <= 1'b0;
            r_bad         <= 1'b0;
            r_pack_done   <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
        end else begin
            r_pack_done   <= 1'b0;
            r_chk_err     <= 1'b0;
            r_timeout_err <= 1'b0;
            r_good        <= 1'b0;
            r_bad         <= 1'b0;

            // Shadow registers are not written in IDLE, so a back-to-back
            // HEAD0 cannot disturb the copy below.
            if (r_good) begin
                r_func_out  <= r_func_sh;
                r_out       <= r_shadow;
                r_pack_done <= 1'b1;
            end
            if (r_bad) begin
                r_chk_err <= 1'b1;
            end

            if (rx_done || r_state == S_IDLE || w_timeout) begin
                r_idle_cnt <= '0;
            end else begin
                r_idle_cnt <= r_idle_cnt + 1'b1;
            end

            if (w_timeout) begin
                r_state       <= S_IDLE;
                r_timeout_err <= 1'b1;
            end else if (rx_done) begin
                case (r_state)
                    S_IDLE: begin
                        if (rx_data == _HEAD0) r_state <= S_HDR1;
                    end
                    S_HDR1: begin
                        if (rx_data == _HEAD1)      r_state <= S_FUNC;
                        else if (rx_data != _HEAD0) r_state <= S_IDLE;
                    end
                    S_FUNC: begin
                        r_func_sh <= rx_data;
                        r_sum     <= rx_data;
                        r_idx     <= '0;
                        r_state   <= S_DATA;
                    end
                    S_DATA: begin
                        r_shadow[r_idx] <= rx_data;
                        r_sum           <= r_sum + rx_data;
                        if (r_idx == 4'd9) begin
                            r_state <= S_CHK;
                        end else begin
                            r_idx <= r_idx + 4'd1;
                        end
                    end
                    S_CHK: begin
                        if (rx_data == r_sum) r_good <= 1'b1;
                        else                  r_bad  <= 1'b1;
                        r_state <= S_IDLE;
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign func_reg    = r_func_out;
    assign rev_data1   = r_out[0];
    assign rev_data2   = r_out[1];
    assign rev_data3   = r_out[2];
    assign rev_data4   = r_out[3];
    assign rev_data5   = r_out[4];
    assign rev_data6   = r_out[5];
    assign rev_data7   = r_out[6];
    assign rev_data8   = r_out[7];
    assign rev_data9   = r_out[8];
    assign rev_data10  = r_out[9];
    assign pack_done   = r_pack_done;
    assign chk_err     = r_chk_err;
    assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_uart_frame_parser.sv
module tb_uart_frame_parser;

    localparam int T = 16;

    logic       clk_50M = 1'b0;
    logic       rst     = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done = 1'b0;
    logic [7:0] func_reg;
    logic [7:0] rev_data1, rev_data2, rev_data3, rev_data4, rev_data5;
    logic [7:0] rev_data6, rev_data7, rev_data8, rev_data9, rev_data10;
    logic       pack_done, chk_err, timeout_err;

    uart_frame_parser #(
        ._HEAD0(8'h55),
        ._HEAD1(8'hAA),
        ._TIMEOUT_CYCLES(T)
    ) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_done    (rx_done),
        .func_reg   (func_reg),
        .rev_data1  (rev_data1),
        .rev_data2  (rev_data2),
        .rev_data3  (rev_data3),
        .rev_data4  (rev_data4),
        .rev_data5  (rev_data5),
        .rev_data6  (rev_data6),
        .rev_data7  (rev_data7),
        .rev_data8  (rev_data8),
        .rev_data9  (rev_data9),
        .rev_data10 (rev_data10),
        .pack_done  (pack_done),
        .chk_err    (chk_err),
        .timeout_err(timeout_err)
    );

    always #10 clk_50M = ~clk_50M;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pack_obs = 0;
    int n_chk_obs  = 0;
    int n_to_obs   = 0;

    task automatic check_val(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference model: a byte buffer holding the frame collected so far,
    // judged as a whole once it reaches 14 bytes.
    logic [7:0] mbuf[$];
    int         m_idle = 0;
    bit         p_good = 0, p_bad = 0;
    logic [7:0] p_func;
    logic [7:0] p_data [10];
    bit         e_pack = 0, e_chk = 0, e_to = 0;
    logic [7:0] e_func = 8'h00;
    logic [7:0] e_data [10] = '{default: 8'h00};

    function automatic void model_byte(input logic [7:0] b);
        int s;
        if (mbuf.size() == 0) begin
            if (b == 8'h55) mbuf.push_back(b);
        end else if (mbuf.size() == 1) begin
            if (b == 8'hAA)      mbuf.push_back(b);
            else if (b != 8'h55) mbuf.delete();
        end else begin
            mbuf.push_back(b);
            if (mbuf.size() == 14) begin
                s = 0;
                for (int i = 2; i <= 12; i++) s += int'(mbuf[i]);
                if ((s % 256) == int'(mbuf[13])) begin
                    p_good = 1;
                    p_func = mbuf[2];
                    for (int i = 0; i < 10; i++) p_data[i] = mbuf[3 + i];
                end else begin
                    p_bad = 1;
                end
                mbuf.delete();
            end
        end
    endfunction

    function automatic void model_edge(input bit v, input logic [7:0] d, input bit r);
        if (r) begin
            mbuf.delete();
            m_idle = 0;
            p_good = 0; p_bad = 0;
            e_pack = 0; e_chk = 0; e_to = 0;
            e_func = 8'h00;
            e_data = '{default: 8'h00};
            return;
        end
        e_pack = p_good;
        e_chk  = p_bad;
        e_to   = 0;
        if (p_good) begin
            e_func = p_func;
            e_data = p_data;
        end
        p_good = 0;
        p_bad  = 0;
        if (v) begin
            m_idle = 0;
            model_byte(d);
        end else if (mbuf.size() != 0) begin
            m_idle++;
            if (m_idle >= T) begin
                e_to = 1;
                mbuf.delete();
                m_idle = 0;
            end
        end
    endfunction

    task automatic step(input bit v, input logic [7:0] d, input bit r);
        @(negedge clk_50M);
        rst     = r;
        rx_done = v;
        rx_data = v ? d : 8'($urandom);
        @(posedge clk_50M);
        #1;
        model_edge(v, d, r);
        n_pack_obs += int'(pack_done);
        n_chk_obs  += int'(chk_err);
        n_to_obs   += int'(timeout_err);
        check_val("pulses", {85'b0, pack_done, chk_err, timeout_err}, {85'b0, e_pack, e_chk, e_to});
        check_val("outputs",
            {func_reg, rev_data1, rev_data2, rev_data3, rev_data4, rev_data5,
             rev_data6, rev_data7, rev_data8, rev_data9, rev_data10},
            {e_func, e_data[0], e_data[1], e_data[2], e_data[3], e_data[4],
             e_data[5], e_data[6], e_data[7], e_data[8], e_data[9]});
    endtask

    task automatic send(input logic [7:0] b, input int gap);
        step(1'b1, b, 1'b0);
        repeat (gap) step(1'b0, 8'h00, 1'b0);
    endtask

    logic [7:0] fr [14];

    function automatic void build_frame(input logic [7:0] f, input logic [7:0] fill, input bit rnd, input bit bad);
        logic [7:0] s;
        fr[0] = 8'h55;
        fr[1] = 8'hAA;
        fr[2] = f;
        s = f;
        for (int i = 0; i < 10; i++) begin
            fr[3 + i] = rnd ? 8'($urandom) : fill;
            s = s + fr[3 + i];
        end
        fr[13] = bad ? s + 8'($urandom_range(1, 255)) : s;
    endfunction

    // tmo_pos: index of the byte followed by a full timeout gap (out of range = none)
    task automatic send_frame(input int first, input int last, input int maxgap, input int tmo_pos);
        for (int i = first; i <= last; i++)
            send(fr[i], (i == tmo_pos) ? T : $urandom_range(0, maxgap));
    endtask

    int pk0, ck0, to0;

    initial begin
        step(1'b0, 8'h00, 1'b1);
        check_val("reset_func", {80'b0, func_reg}, 88'h0);
        check_val("reset_pulses", {85'b0, pack_done, chk_err, timeout_err}, 88'h0);

        // good frame 55 AA 01 02..0B 42
        for (int i = 0; i < 10; i++) fr[3 + i] = 8'(i + 2);
        fr[0] = 8'h55; fr[1] = 8'hAA; fr[2] = 8'h01; fr[13] = 8'h42;
        pk0 = n_pack_obs;
        send_frame(0, 13, 0, 99);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check_val("good_pack_count", 88'(n_pack_obs - pk0), 88'd1);
        check_val("good_func", {80'b0, func_reg}, 88'h01);
        check_val("good_d1", {80'b0, rev_data1}, 88'h02);
        check_val("good_d10", {80'b0, rev_data10}, 88'h0B);

        // same frame with bad checksum 43
        fr[13] = 8'h43;
        pk0 = n_pack_obs; ck0 = n_chk_obs;
        send_frame(0, 13, 2, 99);
        repeat (3) step(1'b0, 8'h00, 1'b0);
        check_val("bad_chk_count", 88'(n_chk_obs - ck0), 88'd1);
        check_val("bad_no_pack", 88'(n_pack_obs - pk0), 88'd0);
        check_val("bad_func_held", {80'b0, func_reg}, 88'h01);
        check_val("bad_d10_held", {80'b0, rev_data10}, 88'h0B);

        // resync: 00 55 55 AA 01 00x10 01
        pk0 = n_pack_obs;
        send(8'h00, 0); send(8'h55, 0); send(8'h55, 1); send(8'hAA, 0); send(8'h01, 0);
        repeat (10) send(8'h00, 0);
        send(8'h01, 0);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        check_val("resync_pack", 88'(n_pack_obs - pk0), 88'd1);
        check_val("resync_func", {80'b0, func_reg}, 88'h01);
        check_val("resync_d5", {80'b0, rev_data5}, 88'h00);

        // timeout after 55 AA 02 03, then a good frame
        to0 = n_to_obs; pk0 = n_pack_obs;
        send(8'h55, 0); send(8'hAA, 0); send(8'h02, 0); send(8'h03, T);
        check_val("timeout_count", 88'(n_to_obs - to0), 88'd1);
        build_frame(8'h33, 8'h00, 1'b1, 1'b0);
        send_frame(0, 13, 1, 99);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        check_val("after_to_pack", 88'(n_pack_obs - pk0), 88'd1);
        check_val("after_to_func", {80'b0, func_reg}, 88'h33);

        // byte exactly on the terminal count continues the frame
        to0 = n_to_obs; pk0 = n_pack_obs;
        build_frame(8'h44, 8'h00, 1'b1, 1'b0);
        send(fr[0], 0); send(fr[1], 0); send(fr[2], T - 1);
        send_frame(3, 13, 0, 99);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        check_val("tc_no_timeout", 88'(n_to_obs - to0), 88'd0);
        check_val("tc_pack", 88'(n_pack_obs - pk0), 88'd1);

        // checksum wrap: all FF, checksum F5
        for (int i = 0; i < 13; i++) fr[i] = 8'hFF;
        fr[0] = 8'h55; fr[1] = 8'hAA; fr[13] = 8'hF5;
        send_frame(0, 13, 0, 99);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        check_val("wrap_func", {80'b0, func_reg}, 88'hFF);
        check_val("wrap_d7", {80'b0, rev_data7}, 88'hFF);

        // reset mid-frame after byte 7
        pk0 = n_pack_obs; ck0 = n_chk_obs; to0 = n_to_obs;
        build_frame(8'h5A, 8'h00, 1'b1, 1'b0);
        send_frame(0, 6, 0, 99);
        step(1'b0, 8'h00, 1'b1);
        check_val("midrst_func", {80'b0, func_reg}, 88'h00);
        check_val("midrst_d1", {80'b0, rev_data1}, 88'h00);
        send_frame(7, 13, 0, 99);
        repeat (T + 2) step(1'b0, 8'h00, 1'b0);
        check_val("midrst_no_pulse", 88'(n_pack_obs - pk0 + n_chk_obs - ck0 + n_to_obs - to0), 88'd0);
        build_frame(8'h5A, 8'h00, 1'b1, 1'b0);
        send_frame(0, 13, 0, 99);
        repeat (2) step(1'b0, 8'h00, 1'b0);
        check_val("midrst_next_pack", 88'(n_pack_obs - pk0), 88'd1);

        // randomized traffic: garbage, good/bad frames, occasional timeouts
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(0, 2)) send(8'($urandom), $urandom_range(0, 2));
            build_frame(8'($urandom), 8'h00, 1'b1, $urandom_range(0, 3) == 0);
            send_frame(0, 13, ($urandom_range(0, 1) == 0) ? 0 : 3,
                       ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 12)) : 99);
        end
        repeat (T + 2) step(1'b0, 8'h00, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
